data_mem_arbiter: RTL

Shares the single data port of main data block RAM between the CPU data path and a second master, the sprite/framebuffer DMA engine. It sits between the memory-mapped I/O decoder's main-memory path and the RAM. CPU requests get priority, bounded by a fairness counter so that DMA is never starved. Read data returns with a tagged valid pulse one cycle after grant.

---
 rtl/data_mem_arbiter_pkg.sv | 7 +
 rtl/data_mem_arbiter_if.sv | 25 ++
 rtl/fair_counter.sv | 17 +
 rtl/data_mem_arbiter.sv | 40 ++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// mem_arb_pkg: shared widths, default fairness bound and read-owner encoding.
package mem_arb_pkg;
  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 16;
  localparam int DEF_CPU_BURST_MAX = 4;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_DMA = 2'd2} rd_owner_t;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: CPU, DMA and RAM-side signals of the data memory arbiter.
// master: requesters plus RAM model; slave: the arbiter.
interface data_mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
);
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    output cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, rdata, mem_addr, mem_we, mem_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    input  cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/fair_counter.sv
// fair_counter: saturating up-counter with synchronous clear, bounded by MAX.
// clk/rst_n: clock and async active-low reset; clr: clear; inc: count up; cnt: value.
module fair_counter #(
  parameter int MAX = 4,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != W'(MAX)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one RAM data port between CPU (priority) and DMA (fairness-bounded).
// clk/rst_n: clock and async active-low reset; bus: requester, read-return and RAM signals.
module data_mem_arbiter import mem_arb_pkg::*; #(
  parameter int CPU_BURST_MAX = DEF_CPU_BURST_MAX
) (
  input logic               clk,
  input logic               rst_n,
  data_mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(CPU_BURST_MAX + 1);
  logic [CW-1:0] burst_cnt;
  logic          cpu_gnt, dma_gnt;
  rd_owner_t     rd_owner, rd_owner_nxt;
  // DMA wins only when alone or once the CPU has used up its burst allowance.
  assign dma_gnt = rst_n && bus.dma_req && (!bus.cpu_req || burst_cnt == CW'(CPU_BURST_MAX));
  assign cpu_gnt = rst_n && bus.cpu_req && !dma_gnt;
  assign bus.cpu_gnt = cpu_gnt;
  assign bus.dma_gnt = dma_gnt;
  assign bus.mem_addr  = dma_gnt ? bus.dma_addr : bus.cpu_addr;
  assign bus.mem_wdata = dma_gnt ? bus.dma_wdata : bus.cpu_wdata;
  assign bus.mem_we    = cpu_gnt ? bus.cpu_we : dma_gnt && bus.dma_we;
  // Counting only matters while DMA waits; any cycle without a DMA request restarts it.
  fair_counter #(.MAX(CPU_BURST_MAX)) u_fair (
    .clk(clk),
    .rst_n(rst_n),
    .clr(dma_gnt || !bus.dma_req),
    .inc(cpu_gnt),
    .cnt(burst_cnt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_owner <= OWN_NONE;
    else rd_owner <= rd_owner_nxt;
  always_comb begin
    rd_owner_nxt = OWN_NONE;
    rd_owner_nxt = (cpu_gnt && !bus.cpu_we) ? OWN_CPU : (dma_gnt && !bus.dma_we) ? OWN_DMA : OWN_NONE;
  end
  assign bus.cpu_rvalid = rd_owner == OWN_CPU;
  assign bus.dma_rvalid = rd_owner == OWN_DMA;
  assign bus.rdata = (rd_owner == OWN_NONE) ? '0 : bus.mem_rdata;
endmodule
